// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   PS2_BREAK / PS2_EXT : scan-code prefixes that are stripped by the decoder
//   KEY_UP / KEY_DOWN   : make codes that the date/time field counters step on
//   FRAME_LEN           : start + 8 data + parity + stop
//   ps2_state_e         : deframer FSM states
//   odd_parity_ok()     : PS/2 odd-parity check of a data byte plus its parity bit
package ps2_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned FRAME_LEN = 11;

  localparam logic [BYTE_W-1:0] PS2_BREAK = 8'hF0;
  localparam logic [BYTE_W-1:0] PS2_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] KEY_UP    = 8'h75;
  localparam logic [BYTE_W-1:0] KEY_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // True when the data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] data, input logic par);
    return (^{data, par}) == 1'b1;
  endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Key-event bus from the PS/2 receiver to the date/time field counters.
//   key_code  : last accepted make code, held between strobes
//   en_codigo : one-cycle strobe, key_code is new
//   ext_flag  : key_code was preceded by E0, valid with en_codigo and held
//   err       : one-cycle pulse on parity, stop or timeout error
// master = receiver side (drives), slave = consumer side.
interface ps2_key_rx_if #(
  parameter int unsigned N = 8
);

  logic [N-1:0] key_code;
  logic         en_codigo;
  logic         ext_flag;
  logic         err;

  modport master (output key_code, en_codigo, ext_flag, err);
  modport slave  (input  key_code, en_codigo, ext_flag, err);

endinterface

// File: rtl/ps2_clk_filter.sv
// Input conditioning for the raw PS/2 lines.
//   clk, rst    : system clock, asynchronous active-low reset
//   ps2_clk_i   : raw keyboard clock (asynchronous)
//   ps2_data_i  : raw keyboard data (asynchronous)
//   data_o      : synchronised data line
//   clk_filt_o  : glitch-filtered keyboard clock
//   fall_o      : one-cycle pulse on a 1->0 transition of clk_filt_o
module ps2_clk_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_o,
  output logic clk_filt_o,
  output logic fall_o
);

  logic                clk_meta_q, clk_sync_q;
  logic                data_meta_q, data_sync_q;
  logic [FILT_LEN-1:0] hist_q, hist_d;
  logic                filt_q, filt_d;
  logic                fall_q, fall_d;

  // Filtered clock only moves once the whole history window agrees.
  always_comb begin
    hist_d = {hist_q[FILT_LEN-2:0], clk_sync_q};
    filt_d = filt_q;
    if (&hist_d)       filt_d = 1'b1;
    else if (~|hist_d) filt_d = 1'b0;
    fall_d = filt_q & ~filt_d;
  end

  // Lines idle high, so everything resets to ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      hist_q      <= '1;
      filt_q      <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
      hist_q      <= hist_d;
      filt_q      <= filt_d;
      fall_q      <= fall_d;
    end
  end

  assign data_o     = data_sync_q;
  assign clk_filt_o = filt_q;
  assign fall_o     = fall_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, strips F0/E0 prefixes and
// presents each make code on the key-event bus.
//   clk, rst  : system clock, asynchronous active-low reset
//   ps2_clk   : raw keyboard clock (asynchronous)
//   ps2_data  : raw keyboard data (asynchronous)
//   key_if    : key_code / en_codigo / ext_flag / err (all registered)
// Build option TYPEMATIC_FILT_EN: suppress auto-repeat of the last strobed
// make code until a break sequence or an error is seen.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned FILT_LEN = 8,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  ps2_key_rx_if.master        key_if
);

  logic data_s, clk_filt, fall;

  ps2_clk_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .data_o     (data_s),
    .clk_filt_o (clk_filt),
    .fall_o     (fall)
  );

  ps2_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [BYTE_W-1:0] shift_q;
  logic              par_q;
  logic [15:0]       wd_q;
  logic              brk_q, brk_d;
  logic              extp_q, extp_d;
  logic [N-1:0]      key_q, key_d;
  logic              extf_q, extf_d;
  logic              en_q, en_d;
  logic              err_q, err_d;

  logic shift_en_c, par_en_c, frame_end_c, frame_ok_c, timeout_c, repeat_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state; a watchdog expiry overrides everything
  always_comb begin
    state_d = state_q;
    if (timeout_c) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (fall && !data_s)            state_d = DATA;
        DATA:    if (fall && bit_cnt_q == 3'd7)  state_d = PARITY;
        PARITY:  if (fall)                       state_d = STOP;
        STOP:    if (fall)                       state_d = IDLE;
        default:                                 state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: datapath enables; a fall on the last tick beats the timeout
  always_comb begin
    shift_en_c  = 1'b0;
    par_en_c    = 1'b0;
    frame_end_c = 1'b0;
    frame_ok_c  = 1'b0;
    timeout_c   = (state_q != IDLE) && !fall && (wd_q == TIMEOUT - 16'd1);
    case (state_q)
      DATA:   shift_en_c = fall;
      PARITY: par_en_c   = fall;
      STOP: begin
        frame_end_c = fall;
        frame_ok_c  = fall && data_s && odd_parity_ok(shift_q, par_q);
      end
      default: ;
    endcase
  end

  // Frame datapath and watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q <= 3'd0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      wd_q      <= 16'd0;
    end else begin
      if (state_q == IDLE && fall) bit_cnt_q <= 3'd0;
      else if (shift_en_c)         bit_cnt_q <= bit_cnt_q + 3'd1;
      if (shift_en_c) shift_q <= {data_s, shift_q[BYTE_W-1:1]};
      if (par_en_c)   par_q   <= data_s;
      if (state_q == IDLE || fall || timeout_c) wd_q <= 16'd0;
      else                                      wd_q <= wd_q + 16'd1;
    end
  end

`ifdef TYPEMATIC_FILT_EN
  logic [BYTE_W:0] last_q, last_d;
  logic            last_vld_q, last_vld_d;

  assign repeat_c = last_vld_q && (last_q == {extp_q, shift_q});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign repeat_c = 1'b0;
`endif

  // Byte decode: prefixes, release suppression and key strobe
  always_comb begin
    brk_d  = brk_q;
    extp_d = extp_q;
    key_d  = key_q;
    extf_d = extf_q;
    en_d   = 1'b0;
    err_d  = 1'b0;
`ifdef TYPEMATIC_FILT_EN
    last_d     = last_q;
    last_vld_d = last_vld_q;
`endif
    if (timeout_c) begin
      err_d = 1'b1;
`ifdef TYPEMATIC_FILT_EN
      last_vld_d = 1'b0;
`endif
    end else if (frame_end_c && !frame_ok_c) begin
      err_d  = 1'b1;
      brk_d  = 1'b0;
      extp_d = 1'b0;
`ifdef TYPEMATIC_FILT_EN
      last_vld_d = 1'b0;
`endif
    end else if (frame_ok_c) begin
      if (shift_q == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (shift_q == PS2_EXT) begin
        extp_d = 1'b1;
      end else if (brk_q) begin
        brk_d  = 1'b0;
        extp_d = 1'b0;
`ifdef TYPEMATIC_FILT_EN
        last_vld_d = 1'b0;
`endif
      end else if (repeat_c) begin
        extp_d = 1'b0;
      end else begin
        key_d  = N'(shift_q);
        extf_d = extp_q;
        en_d   = 1'b1;
        extp_d = 1'b0;
`ifdef TYPEMATIC_FILT_EN
        last_d     = {extp_q, shift_q};
        last_vld_d = 1'b1;
`endif
      end
    end
  end

  // Registered outputs and prefix flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brk_q  <= 1'b0;
      extp_q <= 1'b0;
      key_q  <= '0;
      extf_q <= 1'b0;
      en_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      brk_q  <= brk_d;
      extp_q <= extp_d;
      key_q  <= key_d;
      extf_q <= extf_d;
      en_q   <= en_d;
      err_q  <= err_d;
    end
  end

  assign key_if.key_code  = key_q;
  assign key_if.en_codigo = en_q;
  assign key_if.ext_flag  = extf_q;
  assign key_if.err       = err_q;

  // The filtered clock level is not needed past the fall detector.
  logic unused_c;
  assign unused_c = clk_filt;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: drives bit-banged PS/2 frames and checks
// strobes, key codes, ext flag and error pulses against hand-computed values.
module tb_ps2_key_rx;

  localparam int unsigned N        = 8;
  localparam int unsigned HALF     = 20;
  localparam logic [15:0] TIMEOUT  = 16'd1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_key_rx_if #(.N(N)) kif ();

  ps2_key_rx #(.N(N), .FILT_LEN(8), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_if   (kif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int strobes = 0;
  int errs = 0;
  int overlap = 0;

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (kif.en_codigo === 1'b1) strobes++;
    if (kif.err === 1'b1) errs++;
    if (kif.en_codigo === 1'b1 && kif.err === 1'b1) overlap++;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                             input logic bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // Shift out the first nbits of a frame; optional short glitches on bit 4.
  task automatic send_bits(input logic [10:0] f, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clk(HALF);
      if (glitch && i == 4) begin
        ps2_clk = 1'b0; wait_clk(3); ps2_clk = 1'b1; wait_clk(HALF);
      end
      ps2_clk = 1'b0;
      wait_clk(HALF);
      if (glitch && i == 4) begin
        ps2_clk = 1'b1; wait_clk(3); ps2_clk = 1'b0; wait_clk(HALF);
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0, 1'b0), 11, 1'b0);
    ps2_data = 1'b1;
    wait_clk(HALF);
  endtask

  int s0, e0;

  initial begin
    // Reset state
    wait_clk(3);
    @(negedge clk);
    check("rst_key", int'(kif.key_code), 0);
    check("rst_en", int'(kif.en_codigo), 0);
    check("rst_ext", int'(kif.ext_flag), 0);
    check("rst_err", int'(kif.err), 0);
    rst_n = 1'b1;
    wait_clk(10);

    // Single make code 0x75
    s0 = strobes; e0 = errs;
    send_byte(8'h75);
    check("mk75_strobes", strobes - s0, 1);
    check("mk75_key", int'(kif.key_code), 'h75);
    check("mk75_ext", int'(kif.ext_flag), 0);
    check("mk75_err", errs - e0, 0);

    // Press and release of 0x72: only the press strobes
    s0 = strobes;
    send_byte(8'h72);
    send_byte(8'hF0);
    send_byte(8'h72);
    check("rel72_strobes", strobes - s0, 1);
    check("rel72_key", int'(kif.key_code), 'h72);

    // Extended 0x75, then plain 0x72
    s0 = strobes;
    send_byte(8'hE0);
    send_byte(8'h75);
    check("e0_strobes", strobes - s0, 1);
    check("e0_key", int'(kif.key_code), 'h75);
    check("e0_ext", int'(kif.ext_flag), 1);
    send_byte(8'h72);
    check("plain72_key", int'(kif.key_code), 'h72);
    check("plain72_ext", int'(kif.ext_flag), 0);

    // Parity error and stop-bit error
    s0 = strobes; e0 = errs;
    send_bits(make_frame(8'h75, 1'b1, 1'b0), 11, 1'b0);
    ps2_data = 1'b1; wait_clk(HALF);
    check("par_err", errs - e0, 1);
    check("par_strobes", strobes - s0, 0);
    check("par_key", int'(kif.key_code), 'h72);
    send_bits(make_frame(8'h75, 1'b0, 1'b1), 11, 1'b0);
    ps2_data = 1'b1; wait_clk(HALF);
    check("stop_err", errs - e0, 2);
    check("stop_strobes", strobes - s0, 0);
    check("stop_key", int'(kif.key_code), 'h72);

    // Short glitches on ps2_clk inside a frame are ignored
    s0 = strobes; e0 = errs;
    send_bits(make_frame(8'h75, 1'b0, 1'b0), 11, 1'b1);
    ps2_data = 1'b1; wait_clk(HALF);
    check("glitch_strobes", strobes - s0, 1);
    check("glitch_key", int'(kif.key_code), 'h75);
    check("glitch_err", errs - e0, 0);

    // Partial frame abandoned by the watchdog
    s0 = strobes; e0 = errs;
    send_bits(make_frame(8'h72, 1'b0, 1'b0), 4, 1'b0);
    ps2_data = 1'b1;
    wait_clk(int'(TIMEOUT) + 50);
    check("to_err", errs - e0, 1);
    check("to_strobes", strobes - s0, 0);
    send_byte(8'h72);
    check("to_next_strobes", strobes - s0, 1);
    check("to_next_key", int'(kif.key_code), 'h72);
    check("to_next_err", errs - e0, 1);

    // Reset in the middle of a frame
    send_bits(make_frame(8'h75, 1'b0, 1'b0), 5, 1'b0);
    rst_n = 1'b0;
    ps2_data = 1'b1;
    wait_clk(2);
    @(negedge clk);
    check("mid_rst_key", int'(kif.key_code), 0);
    check("mid_rst_ext", int'(kif.ext_flag), 0);
    check("mid_rst_en", int'(kif.en_codigo), 0);
    check("mid_rst_err", int'(kif.err), 0);
    rst_n = 1'b1;
    wait_clk(HALF);
    s0 = strobes; e0 = errs;
    send_byte(8'h75);
    check("post_rst_strobes", strobes - s0, 1);
    check("post_rst_key", int'(kif.key_code), 'h75);
    check("post_rst_err", errs - e0, 0);

    // Auto-repeat behaviour
    s0 = strobes;
    send_byte(8'hF0);
    send_byte(8'h75);
    check("rpt_release", strobes - s0, 0);
    send_byte(8'h75);
    send_byte(8'h75);
    send_byte(8'h75);
`ifdef TYPEMATIC_FILT_EN
    check("rpt_three", strobes - s0, 1);
`else
    check("rpt_three", strobes - s0, 3);
`endif
    s0 = strobes;
    send_byte(8'hF0);
    send_byte(8'h75);
    send_byte(8'h75);
    check("rpt_after_brk", strobes - s0, 1);
    check("rpt_key", int'(kif.key_code), 'h75);

    check("en_err_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
